// File: rtl/err_inj_pkg.sv
// Shared constants for the fault-injection controller: FSM state encoding,
// default flip-bit positions and the coded-link data width.
package err_inj_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned BIT_A_DEF = 0;
   localparam int unsigned BIT_B_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WINDOW  = 2'd1,
      INJECT  = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/err_inject_ctrl_if.sv
// Injection status bus between the controller and the link XOR stage.
//   flip_mask  : bits to invert on the link this cycle
//   inj_active : high exactly while flip_mask != 0
//   inj_count  : injected events, saturating
//   busy       : controller not idle
// master = controller (drives), slave = datapath/display (observes).
interface err_inject_ctrl_if;
   import err_inj_pkg::*;

   logic [DATA_W-1:0] flip_mask;
   logic              inj_active;
   logic [CNT_W-1:0]  inj_count;
   logic              busy;

   modport master (output flip_mask, inj_active, inj_count, busy);
   modport slave  (input  flip_mask, inj_active, inj_count, busy);
endinterface

// File: rtl/err_inject_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, debounce and press-edge pulse.
//   clk, rstn : clock, async active-low reset
//   btn       : raw asynchronous button, active-high
//   level     : debounced button level (registered)
//   rise      : one-cycle pulse coincident with level going 0->1 (registered)
module btn_debounce #(
   parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn,
   output logic level,
   output logic rise
);
   localparam int unsigned DEB_W = 20;

   logic             sync1;
   logic             sync2;
   logic [DEB_W-1:0] cnt;

   // cnt counts consecutive cycles the synced input disagrees with level;
   // any agreement (bounce back) clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DEB_CYCLES - 20'd1) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end
endmodule

// File: rtl/err_inject_ctrl.sv
// Fault-injection sequencer: turns each debounced press of btn1/btn2 into one
// timed flip_mask event on the coded data link, merging presses that fall in a
// short combine window, and counts issued events.
//   clk, rstn  : clock, async active-low reset
//   btn1, btn2 : raw buttons (flip BIT_A / BIT_B)
//   bus        : err_inject_ctrl_if.master (flip_mask, inj_active, inj_count, busy)
// Build option: ERR_INJ_BURST_EN holds flip_mask for BURST_LEN cycles per event;
// without it each event is a single-cycle flip.
module err_inject_ctrl
   import err_inj_pkg::*;
#(
   parameter logic [19:0] DEB_CYCLES  = 20'd500000,
   parameter logic [15:0] COMB_CYCLES = 16'd1000,
   parameter int unsigned BIT_A       = BIT_A_DEF,
   parameter int unsigned BIT_B       = BIT_B_DEF,
   parameter int unsigned BURST_LEN   = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               btn1,
   input  logic               btn2,
   err_inject_ctrl_if.master  bus
);
   localparam int unsigned WIN_W = 16;
   localparam logic [DATA_W-1:0] MASK_A = DATA_W'(1) << BIT_A;
   localparam logic [DATA_W-1:0] MASK_B = DATA_W'(1) << BIT_B;

   // Reject configurations that would alias or drop a flip bit.
   if (BIT_A == BIT_B || BIT_A >= DATA_W || BIT_B >= DATA_W || BURST_LEN == 0) begin : g_bad_cfg
      $error("err_inject_ctrl: invalid BIT_A/BIT_B/BURST_LEN");
   end

   logic db1, db2, rise1, rise2;
   logic [DATA_W-1:0] edge_bits_c;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db1 (
      .clk(clk), .rstn(rstn), .btn(btn1), .level(db1), .rise(rise1)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db2 (
      .clk(clk), .rstn(rstn), .btn(btn2), .level(db2), .rise(rise2)
   );

   assign edge_bits_c = (rise1 ? MASK_A : '0) | (rise2 ? MASK_B : '0);

   state_t            state;
   logic [WIN_W-1:0]  win_cnt;
   logic [DATA_W-1:0] mask;
`ifdef ERR_INJ_BURST_EN
   localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
   logic [BURST_W-1:0] burst_cnt;
`endif

   // Sequencer FSM; all bus outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         win_cnt        <= '0;
         mask           <= '0;
         bus.flip_mask  <= '0;
         bus.inj_active <= 1'b0;
         bus.inj_count  <= '0;
         bus.busy       <= 1'b0;
`ifdef ERR_INJ_BURST_EN
         burst_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|edge_bits_c) begin
                  mask     <= edge_bits_c;
                  win_cnt  <= COMB_CYCLES - 16'd1;
                  state    <= WINDOW;
                  bus.busy <= 1'b1;
               end
            end
            WINDOW: begin
               // Late presses merge into the latch, including on the final cycle.
               mask <= mask | edge_bits_c;
               if (win_cnt == '0) begin
                  state          <= INJECT;
                  bus.flip_mask  <= mask | edge_bits_c;
                  bus.inj_active <= |(mask | edge_bits_c);
                  if (bus.inj_count != 8'hFF) begin
                     bus.inj_count <= bus.inj_count + 8'd1;
                  end
`ifdef ERR_INJ_BURST_EN
                  burst_cnt <= BURST_W'(BURST_LEN - 1);
`endif
               end else begin
                  win_cnt <= win_cnt - 16'd1;
               end
            end
            INJECT: begin
`ifdef ERR_INJ_BURST_EN
               if (burst_cnt != '0) begin
                  burst_cnt <= burst_cnt - BURST_W'(1);
               end else begin
                  bus.flip_mask  <= '0;
                  bus.inj_active <= 1'b0;
                  state          <= RELEASE;
               end
`else
               bus.flip_mask  <= '0;
               bus.inj_active <= 1'b0;
               state          <= RELEASE;
`endif
            end
            RELEASE: begin
               // New presses are dropped until both buttons are released.
               if (!db1 && !db2) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_err_inject_ctrl.sv
// Scoreboard bench for err_inject_ctrl (DEB_CYCLES=4, COMB_CYCLES=8, BURST_LEN=4).
module tb_err_inject_ctrl;
   import err_inj_pkg::*;

   localparam logic [19:0] DEB  = 20'd4;
   localparam logic [15:0] COMB = 16'd8;
   localparam int unsigned BLEN = 4;
   // Button driven at a negedge -> flip_mask seen at the negedge LAT cycles later:
   // 2 sync + 4 debounce + 1 IDLE->WINDOW + 8 window.
   localparam int LAT = 15;
`ifdef ERR_INJ_BURST_EN
   localparam int EXP_LEN = 4;
`else
   localparam int EXP_LEN = 1;
`endif

   typedef struct {
      logic [7:0] mask;
      logic [7:0] count;
      int         cyc;
      int         len;
   } exp_t;

   exp_t q[$];

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic btn1 = 1'b0;
   logic btn2 = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   err_inject_ctrl_if bus ();

   err_inject_ctrl #(
      .DEB_CYCLES(DEB), .COMB_CYCLES(COMB), .BIT_A(0), .BIT_B(4), .BURST_LEN(BLEN)
   ) dut (
      .clk(clk), .rstn(rstn), .btn1(btn1), .btn2(btn2), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] m, input logic [7:0] c, input int len);
      exp_t e;
      e.mask  = m;
      e.count = c;
      e.cyc   = cyc + LAT;
      e.len   = len;
      q.push_back(e);
   endtask

   task automatic do_reset();
      btn1 = 1'b0;
      btn2 = 1'b0;
      rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
      tick(2);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         tick(1);
         n++;
      end
      check(name, 32'(bus.busy), 32'd0);
      tick(4);
   endtask

   task automatic check_reset_outs(input string name);
      check({name, "_flip"},   32'(bus.flip_mask),  32'd0);
      check({name, "_active"}, 32'(bus.inj_active), 32'd0);
      check({name, "_count"},  32'(bus.inj_count),  32'd0);
      check({name, "_busy"},   32'(bus.busy),       32'd0);
   endtask

   // Monitor: every flip_mask run must match the next scoreboard entry.
   initial begin
      exp_t cur;
      int   run;
      run = 0;
      cur.mask = 8'h00; cur.count = 8'h00; cur.cyc = 0; cur.len = 0;
      forever begin
         @(negedge clk);
         check("inj_active_vs_mask", 32'(bus.inj_active), 32'(|bus.flip_mask));
         if (bus.flip_mask != 8'h00) begin
            if (run == 0) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_pulse: got flip_mask=%0h, expected none", bus.flip_mask);
                  cur.mask = bus.flip_mask; cur.count = bus.inj_count; cur.cyc = 0; cur.len = 0;
               end else begin
                  cur = q.pop_front();
                  check("pulse_mask",  32'(bus.flip_mask), 32'(cur.mask));
                  check("pulse_count", 32'(bus.inj_count), 32'(cur.count));
                  check("pulse_cycle", 32'(cyc),           32'(cur.cyc));
               end
            end else begin
               check("burst_mask_stable", 32'(bus.flip_mask), 32'(cur.mask));
            end
            run++;
         end else if (run != 0) begin
            if (cur.len > 0) check("pulse_length", 32'(run), 32'(cur.len));
            run = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(2);
      check_reset_outs("reset");
      rstn = 1'b1;
      tick(2);

      // 1: bouncing btn1 then a clean hold -> one 0x01 event
      do_reset();
      repeat (3) begin
         btn1 = 1'b1; tick(1);
         btn1 = 1'b0; tick(1);
      end
      btn1 = 1'b1;
      push(8'h01, 8'd1, EXP_LEN);
      tick(20);
      btn1 = 1'b0;
      wait_idle("t1_idle");
      check("t1_count", 32'(bus.inj_count), 32'd1);

      // 2: btn2 then btn1 three cycles later -> merged 0x11
      do_reset();
      btn2 = 1'b1;
      push(8'h11, 8'd1, EXP_LEN);
      tick(3);
      btn1 = 1'b1;
      tick(20);
      btn1 = 1'b0;
      btn2 = 1'b0;
      wait_idle("t2_idle");
      check("t2_count", 32'(bus.inj_count), 32'd1);

      // 3: btn2 pressed after the window closed -> ignored until both released
      do_reset();
      btn1 = 1'b1;
      push(8'h01, 8'd1, EXP_LEN);
      tick(12);
      btn2 = 1'b1;
      tick(10);
      check("t3_busy_both_held", 32'(bus.busy), 32'd1);
      btn1 = 1'b0;
      tick(15);
      check("t3_busy_btn2_held", 32'(bus.busy), 32'd1);
      btn2 = 1'b0;
      wait_idle("t3_idle");
      tick(30);
      check("t3_count", 32'(bus.inj_count), 32'd1);

      // 4: 300 presses -> count saturates at 0xFF
      do_reset();
      for (int i = 0; i < 300; i++) begin
         btn1 = 1'b1;
         push(8'h01, (i < 255) ? 8'(i + 1) : 8'hFF, EXP_LEN);
         tick(20);
         btn1 = 1'b0;
         wait_idle("t4_idle");
      end
      check("t4_count_sat", 32'(bus.inj_count), 32'hFF);

      // 5a: reset during WINDOW -> no event
      do_reset();
      btn1 = 1'b1;
      tick(10);
      check("t5a_busy_window", 32'(bus.busy), 32'd1);
      rstn = 1'b0;
      #1;
      check_reset_outs("t5a_rst");
      btn1 = 1'b0;
      tick(3);
      rstn = 1'b1;
      tick(40);
      check("t5a_busy_after", 32'(bus.busy), 32'd0);
      check("t5a_count_after", 32'(bus.inj_count), 32'd0);

      // 5b: reset during INJECT -> flip cut after its first cycle
      do_reset();
      btn1 = 1'b1;
      push(8'h01, 8'd1, 1);
      tick(LAT);
      #2;
      check("t5b_flip_before_rst", 32'(bus.flip_mask), 32'h01);
      rstn = 1'b0;
      #1;
      check_reset_outs("t5b_rst");
      btn1 = 1'b0;
      tick(3);
      rstn = 1'b1;
      tick(40);
      check("t5b_count_after", 32'(bus.inj_count), 32'd0);

      // 6: btn2 alone -> 0x10 (burst length when built with the burst option)
      do_reset();
      btn2 = 1'b1;
      push(8'h10, 8'd1, EXP_LEN);
      tick(20);
      btn2 = 1'b0;
      wait_idle("t6_idle");
      check("t6_count", 32'(bus.inj_count), 32'd1);

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
